// File: rtl/boid_update_seq.sv
`default_nettype none
// ============================================================================
// Module   : boid_update_seq
// Brief    : Frame sequencer for the boid update datapath. It loads each self
//            boid, scans all boids as neighbours, drains the pipeline, then
//            writes back. Optional macro: BOID_SEQ_SELF_SKIP_EN (do not
//            accumulate the self boid).
// Revision : 1.0 - initial release
// ============================================================================
module boid_update_seq #(
  parameter int N_BOIDS = 64,
  parameter int ADDR_W  = 10,
  parameter int WB_LAT  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              r_en_tot,
  output logic              r_en_itr,
  output logic [6:0]        wb_en
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TOT   = 3'd2,
    S_SCAN  = 3'd3,
    S_DRAIN = 3'd4,
    S_WB    = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(N_BOIDS - 1);
  localparam logic [ADDR_W-1:0] c_one      = ADDR_W'(1);
  localparam logic [2:0]        c_wb_last  = 3'(WB_LAT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [2:0]        wb_cnt_q, wb_cnt_d;
  logic              itr_q, itr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      wb_cnt_q <= '0;
      itr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      wb_cnt_q <= wb_cnt_d;
      itr_q    <= itr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    wb_cnt_d = wb_cnt_q;
    itr_d    = 1'b0;
    busy     = (state_q != S_IDLE);
    done     = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    r_en_tot = 1'b0;
    r_en_itr = itr_q;
    wb_en    = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          i_d     = '0;
        end
      end
      S_LOAD: begin
        rd_en   = 1'b1;
        rd_addr = i_q;
        state_d = S_TOT;
      end
      S_TOT: begin
        r_en_tot = 1'b1;
        j_d      = '0;
        state_d  = S_SCAN;
      end
      S_SCAN: begin
        rd_en   = 1'b1;
        rd_addr = j_q;
`ifdef BOID_SEQ_SELF_SKIP_EN
        itr_d   = (j_q != i_q);
`else
        itr_d   = 1'b1;
`endif
        if (j_q == c_last_idx) begin
          j_d     = '0;
          state_d = S_DRAIN;
        end else begin
          j_d = j_q + c_one;
        end
      end
      S_DRAIN: begin
        wb_cnt_d = '0;
        state_d  = S_WB;
      end
      S_WB: begin
        wb_en[0] = 1'b1;
        // Stage k of the writeback pipe is enabled only in WB cycle k.
        for (int k = 1; k < 7; k++) begin
          if ((k <= WB_LAT) && (wb_cnt_q == 3'(k))) begin
            wb_en[k] = 1'b1;
          end
        end
        if (wb_cnt_q == c_wb_last) begin
          wr_en    = 1'b1;
          wr_addr  = i_q;
          wb_cnt_d = '0;
          if (i_q < c_last_idx) begin
            i_d     = i_q + c_one;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          wb_cnt_d = wb_cnt_q + 3'd1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_boid_update_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_boid_update_seq
// Brief    : Directed bench for boid_update_seq with N_BOIDS=4 (WB_LAT 0 and 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_boid_update_seq;

`ifdef BOID_SEQ_SELF_SKIP_EN
  localparam int EXP_ITR = 3;
  localparam logic EXP_GAP = 1'b0;
`else
  localparam int EXP_ITR = 4;
  localparam logic EXP_GAP = 1'b1;
`endif

  logic clk;
  int   errors = 0;
  int   checks = 0;

  logic       rst_a, start_a, a_busy, a_done, a_rd_en, a_wr_en, a_tot, a_itr;
  logic [9:0] a_rd_addr, a_wr_addr;
  logic [6:0] a_wb_en;
  logic       rst_b, start_b, b_busy, b_done, b_rd_en, b_wr_en, b_tot, b_itr;
  logic [9:0] b_rd_addr, b_wr_addr;
  logic [6:0] b_wb_en;

  boid_update_seq #(.N_BOIDS(4), .ADDR_W(10), .WB_LAT(0)) u_dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .busy(a_busy), .done(a_done),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .r_en_tot(a_tot), .r_en_itr(a_itr), .wb_en(a_wb_en)
  );

  boid_update_seq #(.N_BOIDS(4), .ADDR_W(10), .WB_LAT(2)) u_dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .r_en_tot(b_tot), .r_en_itr(b_itr), .wb_en(b_wb_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] outs_a();
    return {a_busy, a_done, a_rd_en, a_rd_addr, a_wr_en, a_wr_addr, a_tot, a_itr, a_wb_en};
  endfunction

  function automatic logic [32:0] outs_b();
    return {b_busy, b_done, b_rd_en, b_rd_addr, b_wr_en, b_wr_addr, b_tot, b_itr, b_wb_en};
  endfunction

  // Mutual-exclusion invariants, checked every cycle on both instances.
  always @(negedge clk) begin
    if (!rst_a && !rst_b) begin
      checks++;
      assert (!(a_rd_en && a_wr_en) && !(b_rd_en && b_wr_en)) else begin
        errors++;
        $display("FAIL excl_rd_wr: a=%b%b b=%b%b required not both", a_rd_en, a_wr_en, b_rd_en, b_wr_en);
      end
      checks++;
      assert (!(a_tot && a_itr) && !(b_tot && b_itr)) else begin
        errors++;
        $display("FAIL excl_tot_itr: a=%b%b b=%b%b required not both", a_tot, a_itr, b_tot, b_itr);
      end
    end
  end

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b1; start_b = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (outs_a() !== 33'd0) begin
      errors++; $display("FAIL reset_a: got %h required 0", outs_a());
    end
    checks++;
    if (outs_b() !== 33'd0) begin
      errors++; $display("FAIL reset_b: got %h required 0", outs_b());
    end
    start_a = 1'b0; start_b = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    checks++;
    if (outs_a() !== 33'd0 || outs_b() !== 33'd0) begin
      errors++; $display("FAIL idle_after_reset: a=%h b=%h required 0", outs_a(), outs_b());
    end
  endtask

  task automatic test_frame();
    int busy_cnt = 0, first_busy = -1, last_busy = -1;
    int done_cnt = 0, done_cyc = -1, wr_cnt = 0, itr_cnt = 0;
    logic [9:0] wr_addrs [4];
    logic [9:0] rd_seq [$];
    logic [9:0] exp_seq [5] = '{10'd2, 10'd0, 10'd1, 10'd2, 10'd3};
    @(negedge clk); start_a = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (c == 1) start_a = 1'b0;
      if (a_busy) begin
        busy_cnt++; if (first_busy < 0) first_busy = c; last_busy = c;
      end
      if (a_done) begin done_cnt++; done_cyc = c; end
      if (a_wr_en) begin
        if (wr_cnt < 4) wr_addrs[wr_cnt] = a_wr_addr;
        wr_cnt++;
      end
      if (c >= 17 && c <= 22 && a_rd_en) rd_seq.push_back(a_rd_addr);
      if (c >= 17 && c <= 24 && a_itr) itr_cnt++;
      if (c == 1) begin
        checks++;
        if (a_rd_en !== 1'b1 || a_rd_addr !== 10'd0) begin
          errors++; $display("FAIL load_cycle1: rd_en=%b addr=%0d required 1,0", a_rd_en, a_rd_addr);
        end
      end
      if (c == 2) begin
        checks++;
        if (a_tot !== 1'b1 || a_rd_en !== 1'b0) begin
          errors++; $display("FAIL tot_cycle2: tot=%b rd_en=%b required 1,0", a_tot, a_rd_en);
        end
      end
      if (c == 8) begin
        checks++;
        if (a_wb_en !== 7'h01 || a_wr_en !== 1'b1 || a_wr_addr !== 10'd0) begin
          errors++; $display("FAIL wb_boid0: wb_en=%h wr=%b addr=%0d required 01,1,0", a_wb_en, a_wr_en, a_wr_addr);
        end
      end
      if (c == 22) begin
        checks++;
        if (a_itr !== EXP_GAP) begin
          errors++; $display("FAIL itr_self_gap: got %b required %b", a_itr, EXP_GAP);
        end
      end
      if (c == 34) begin
        checks++;
        if (outs_a() !== 33'd0) begin
          errors++; $display("FAIL idle_after_done: got %h required 0", outs_a());
        end
      end
    end
    checks++;
    if (busy_cnt != 33 || first_busy != 1 || last_busy != 33) begin
      errors++; $display("FAIL busy_window: cnt=%0d first=%0d last=%0d required 33,1,33", busy_cnt, first_busy, last_busy);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 33) begin
      errors++; $display("FAIL done_timing: cnt=%0d cyc=%0d required 1,33", done_cnt, done_cyc);
    end
    checks++;
    if (wr_cnt != 4) begin
      errors++; $display("FAIL write_count: got %0d required 4", wr_cnt);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wr_addrs[k] !== 10'(k)) begin
          errors++; $display("FAIL write_addr%0d: got %0d required %0d", k, wr_addrs[k], k);
        end
      end
    end
    checks++;
    if (rd_seq.size() != 5) begin
      errors++; $display("FAIL rd_seq_len: got %0d required 5", rd_seq.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (rd_seq[k] !== exp_seq[k]) begin
          errors++; $display("FAIL rd_seq%0d: got %0d required %0d", k, rd_seq[k], exp_seq[k]);
        end
      end
    end
    checks++;
    if (itr_cnt != EXP_ITR) begin
      errors++; $display("FAIL itr_count: got %0d required %0d", itr_cnt, EXP_ITR);
    end
  endtask

  task automatic test_wb_lat();
    int wr_cnt = 0, done_cnt = 0, done_cyc = -1;
    logic [6:0] exp_wb [3] = '{7'h01, 7'h03, 7'h05};
    @(negedge clk); start_b = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 43; c++) begin
      @(negedge clk);
      if (c == 1) start_b = 1'b0;
      if (b_wr_en) wr_cnt++;
      if (b_done) begin done_cnt++; done_cyc = c; end
      if (c >= 8 && c <= 10) begin
        checks++;
        if (b_wb_en !== exp_wb[c-8]) begin
          errors++; $display("FAIL wb_en_c%0d: got %h required %h", c, b_wb_en, exp_wb[c-8]);
        end
        checks++;
        if (b_wr_en !== (c == 10) || (c == 10 && b_wr_addr !== 10'd0)) begin
          errors++; $display("FAIL wr_en_c%0d: got %b addr=%0d required %b,0", c, b_wr_en, b_wr_addr, c == 10);
        end
      end
      if (c == 11) begin
        checks++;
        if (b_wb_en !== 7'h00 || b_rd_en !== 1'b1 || b_rd_addr !== 10'd1) begin
          errors++; $display("FAIL load_boid1_b: wb_en=%h rd=%b addr=%0d required 00,1,1", b_wb_en, b_rd_en, b_rd_addr);
        end
      end
    end
    checks++;
    if (wr_cnt != 4 || done_cnt != 1 || done_cyc != 41) begin
      errors++; $display("FAIL frame_b: writes=%0d done=%0d at %0d required 4,1,41", wr_cnt, done_cnt, done_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (a_done && c <= 34) done_cnt++;
      if (c == 9) begin
        checks++;
        if (a_rd_en !== 1'b1 || a_rd_addr !== 10'd1) begin
          errors++; $display("FAIL b2b_midframe: rd=%b addr=%0d required 1,1", a_rd_en, a_rd_addr);
        end
      end
      if (c == 34) begin
        checks++;
        if (a_busy !== 1'b0) begin
          errors++; $display("FAIL b2b_idle_gap: busy=%b required 0", a_busy);
        end
      end
      if (c == 35) begin
        checks++;
        if (a_busy !== 1'b1 || a_rd_en !== 1'b1 || a_rd_addr !== 10'd0) begin
          errors++; $display("FAIL b2b_relaunch: busy=%b rd=%b addr=%0d required 1,1,0", a_busy, a_rd_en, a_rd_addr);
        end
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL b2b_done_count: got %0d required 1", done_cnt);
    end
    start_a = 1'b0; rst_a = 1'b1;
    @(negedge clk); rst_a = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int bad = 0;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start_a = 1'b0;
      if (c == 11) begin
        checks++;
        if (a_rd_en !== 1'b1 || a_rd_addr !== 10'd0 || a_busy !== 1'b1) begin
          errors++; $display("FAIL scan_boid1: rd=%b addr=%0d busy=%b required 1,0,1", a_rd_en, a_rd_addr, a_busy);
        end
      end
    end
    rst_a = 1'b1;
    @(negedge clk); rst_a = 1'b0;
    checks++;
    if (outs_a() !== 33'd0) begin
      errors++; $display("FAIL abort_outputs: got %h required 0", outs_a());
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (a_wr_en || a_done || a_busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL abort_quiet: active cycles=%0d required 0", bad);
    end
    @(negedge clk); start_a = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start_a = 1'b0;
        checks++;
        if (a_rd_en !== 1'b1 || a_rd_addr !== 10'd0) begin
          errors++; $display("FAIL restart_load: rd=%b addr=%0d required 1,0", a_rd_en, a_rd_addr);
        end
      end
      if (c == 8) begin
        checks++;
        if (a_wr_en !== 1'b1 || a_wr_addr !== 10'd0) begin
          errors++; $display("FAIL restart_write: wr=%b addr=%0d required 1,0", a_wr_en, a_wr_addr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_wb_lat();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
